rsa_word_bridge: RTL

- Word-serial front end for the RSA modular-exponentiation core.
- Collects message, exponent and modulus as WORDW-bit beats over a valid/ready stream and presents them to the core as full KEYSIZE-bit operands.
- Pulses the core's `ds`, waits for completion, captures `cypher`, and streams the result back out word by word.
- Sits between the system word bus and the exponentiation core.

---
 rtl/rsa_pkg.sv | 8 +
 rtl/rsa_word_shreg.sv | 39 +++
 rtl/rsa_word_bridge.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and default sizes for the RSA word bridge
package rsa_pkg;
  localparam int KEYSIZE_DEF = 2048;
  localparam int WORDW_DEF   = 32;

  typedef enum logic [2:0] {LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD} state_e;
  typedef enum logic [1:0] {DATA, EXP, MOD} field_e;
endpackage

// File: rtl/rsa_word_shreg.sv
// rtl/rsa_word_shreg.sv - KEYSIZE-wide register with parallel load and WORDW-step right shift
module rsa_word_shreg
  import rsa_pkg::*;
#(
  parameter int KEYSIZE = KEYSIZE_DEF,
  parameter int WORDW   = WORDW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [KEYSIZE-1:0] load_data_i,
  input  logic               shift_i,
  input  logic [WORDW-1:0]   shift_in_i,
  output logic [KEYSIZE-1:0] q_o
);
  logic [KEYSIZE-1:0] q_q, q_d, ins;

  // New word enters at the top so the first word ends up in the bottom slot.
  assign ins = KEYSIZE'(shift_in_i) << (KEYSIZE - WORDW);

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_data_i;
    end else if (shift_i) begin
      q_d = (q_q >> WORDW) | ins;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/rsa_word_bridge.sv
// rtl/rsa_word_bridge.sv - word-serial front end for the RSA exponentiation core
// Optional zero-modulus bypass: RSA_BRIDGE_ZERO_MOD_CHECK_EN
module rsa_word_bridge
  import rsa_pkg::*;
#(
  parameter int KEYSIZE = KEYSIZE_DEF,
  parameter int WORDW   = WORDW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDW-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err,
  output logic [KEYSIZE-1:0] core_indata,
  output logic [KEYSIZE-1:0] core_exp,
  output logic [KEYSIZE-1:0] core_mod,
  output logic               core_ds,
  input  logic [KEYSIZE-1:0] core_cypher,
  input  logic               core_ready
);
  localparam int NWORDS = KEYSIZE / WORDW;
  localparam int CNTW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NWORDS - 1);

  state_e            state_q, state_d;
  field_e            field_q, field_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              cnt_last;
  logic              sh_data, sh_exp, sh_mod, res_load, res_shift;
  logic [KEYSIZE-1:0] res_load_data, data_q, exp_q, mod_q, res_q;
`ifdef RSA_BRIDGE_ZERO_MOD_CHECK_EN
  logic              err_q, err_d;
`endif

  assign cnt_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d       = state_q;
    field_d       = field_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    core_ds       = 1'b0;
    sh_data       = 1'b0;
    sh_exp        = 1'b0;
    sh_mod        = 1'b0;
    res_load      = 1'b0;
    res_load_data = core_cypher;
    res_shift     = 1'b0;
`ifdef RSA_BRIDGE_ZERO_MOD_CHECK_EN
    err_d         = err_q;
`endif
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_data = (field_q == DATA);
          sh_exp  = (field_q == EXP);
          sh_mod  = (field_q == MOD);
`ifdef RSA_BRIDGE_ZERO_MOD_CHECK_EN
          if (field_q == DATA && cnt_q == '0) err_d = 1'b0;
`endif
          if (cnt_last) begin
            cnt_d = '0;
            case (field_q)
              DATA:    field_d = EXP;
              EXP:     field_d = MOD;
              default: begin
                field_d = DATA;
                state_d = START;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
`ifdef RSA_BRIDGE_ZERO_MOD_CHECK_EN
        if (mod_q == '0) begin
          res_load      = 1'b1;
          res_load_data = '0;
          err_d         = 1'b1;
          state_d       = UNLOAD;
        end else
`endif
        if (core_ready) begin
          core_ds = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      // Waiting for ready to drop keeps a stale cypher from being taken as the answer.
      WAIT_BUSY: if (!core_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (core_ready) begin
          res_load = 1'b1;
          state_d  = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          res_shift = 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      field_q <= DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RSA_BRIDGE_ZERO_MOD_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  rsa_word_shreg #(.KEYSIZE(KEYSIZE), .WORDW(WORDW)) u_data (
    .clk(clk), .reset_n(reset_n), .load_i(1'b0), .load_data_i('0),
    .shift_i(sh_data), .shift_in_i(in_data), .q_o(data_q)
  );
  rsa_word_shreg #(.KEYSIZE(KEYSIZE), .WORDW(WORDW)) u_exp (
    .clk(clk), .reset_n(reset_n), .load_i(1'b0), .load_data_i('0),
    .shift_i(sh_exp), .shift_in_i(in_data), .q_o(exp_q)
  );
  rsa_word_shreg #(.KEYSIZE(KEYSIZE), .WORDW(WORDW)) u_mod (
    .clk(clk), .reset_n(reset_n), .load_i(1'b0), .load_data_i('0),
    .shift_i(sh_mod), .shift_in_i(in_data), .q_o(mod_q)
  );
  rsa_word_shreg #(.KEYSIZE(KEYSIZE), .WORDW(WORDW)) u_res (
    .clk(clk), .reset_n(reset_n), .load_i(res_load), .load_data_i(res_load_data),
    .shift_i(res_shift), .shift_in_i('0), .q_o(res_q)
  );

  assign core_indata = data_q;
  assign core_exp    = exp_q;
  assign core_mod    = mod_q;
  assign out_data    = res_q[WORDW-1:0];
  assign out_last    = (state_q == UNLOAD) && cnt_last;
  assign busy        = (state_q != LOAD) || (field_q != DATA) || (cnt_q != '0);
endmodule
